// File: rtl/slot_output_mixer.sv
// -----------------------------------------------------------------------------
// slot_output_mixer
//
// Reader side of the per-slot operator output memory. Once per sample frame it
// walks all slot entries through the memory's second read port, converts each
// sign+magnitude sample to two's complement, accumulates carrier outputs into
// separate melody and rhythm sums, and publishes a mixed audio sample with a
// one-clock valid strobe.
//
// Ports:
//   clk          clock
//   reset        asynchronous, active-high reset
//   clkena       clock enable; state advances only on enabled edges
//   start        frame start request (sampled on clkena cycles)
//   rhythm       rhythm-mode flag, latched when start is accepted
//   maddr        registered slot address to the output memory read port
//   mdata        read data: [9]=sign (1=negative), [8:0]=magnitude
//   melody_out   signed melody sum of the last completed frame
//   rhythm_out   signed rhythm sum of the last completed frame
//   mix_out      saturated melody_out + (rhythm_out <<< RHY_SHIFT)
//   sample_valid one-clk pulse when the outputs update
//   busy         high from start acceptance until sample_valid
//   overrun      sticky; set when start arrives while busy
// -----------------------------------------------------------------------------
module slot_output_mixer #(
    parameter int NSLOTS    = 18,
    parameter int ACC_W     = 14,
    parameter int OUT_W     = 14,
    parameter int RHY_SHIFT = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clkena,
    input  logic                    start,
    input  logic                    rhythm,
    output logic [4:0]              maddr,
    input  logic [9:0]              mdata,
    output logic signed [ACC_W-1:0] melody_out,
    output logic signed [ACC_W-1:0] rhythm_out,
    output logic signed [OUT_W-1:0] mix_out,
    output logic                    sample_valid,
    output logic                    busy,
    output logic                    overrun
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_PUBLISH
    } state_t;

    localparam logic [4:0] LAST_SLOT = 5'(NSLOTS - 1);
    localparam logic [4:0] PRE_LAST  = 5'(NSLOTS - 2);
    // First slot routed to the rhythm sum in rhythm mode (BD carrier).
    localparam logic [4:0] RHY_FIRST = 5'd13;

    // Wide enough for melody + shifted rhythm plus one guard bit.
    localparam int MIX_W = (((ACC_W + RHY_SHIFT + 1) > OUT_W) ? (ACC_W + RHY_SHIFT + 1) : OUT_W) + 1;
    localparam logic signed [MIX_W-1:0] SAT_MAX = {{(MIX_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [MIX_W-1:0] SAT_MIN = -SAT_MAX;

    state_t                  state_q,    state_d;
    logic [4:0]              maddr_q,    maddr_d;
    logic                    rhy_q,      rhy_d;
    // Slot-tag pipeline: tag0 = address just issued, tag1 = slot whose data is
    // on mdata now (two enabled cycles of read latency).
    logic                    tag0_vld_q, tag0_vld_d;
    logic [4:0]              tag0_q,     tag0_d;
    logic                    tag1_vld_q, tag1_vld_d;
    logic [4:0]              tag1_q,     tag1_d;
    logic signed [ACC_W-1:0] acc_mel_q,  acc_mel_d;
    logic signed [ACC_W-1:0] acc_rhy_q,  acc_rhy_d;
    logic signed [ACC_W-1:0] mel_out_q,  mel_out_d;
    logic signed [ACC_W-1:0] rhy_out_q,  rhy_out_d;
    logic signed [OUT_W-1:0] mix_q,      mix_d;
    logic                    valid_q,    valid_d;
    logic                    busy_q,     busy_d;
    logic                    overrun_q,  overrun_d;

    // Sign+magnitude to two's complement; negative zero naturally maps to 0.
    logic signed [ACC_W-1:0] mag_ext;
    logic signed [ACC_W-1:0] sample_val;
    assign mag_ext    = ACC_W'(mdata[8:0]);
    assign sample_val = mdata[9] ? -mag_ext : mag_ext;

    // Routing of the slot currently on mdata. In rhythm mode slots 13..17
    // (BD carrier, HH, SD, TOM, CYM) feed the rhythm sum; slot 12 (BD
    // modulator) falls through as an even slot and is dropped.
    logic to_rhy;
    logic to_mel;
    assign to_rhy = rhy_q && (tag1_q >= RHY_FIRST);
    assign to_mel = tag1_q[0] && !to_rhy;

    // Mix with saturation to the symmetric output range.
    logic signed [MIX_W-1:0] mel_wide;
    logic signed [MIX_W-1:0] rhy_wide;
    logic signed [MIX_W-1:0] mix_wide;
    logic signed [OUT_W-1:0] mix_sat;
    assign mel_wide = MIX_W'(acc_mel_q);
    assign rhy_wide = MIX_W'(acc_rhy_q);
    assign mix_wide = mel_wide + (rhy_wide <<< RHY_SHIFT);

    always_comb begin
        mix_sat = mix_wide[OUT_W-1:0];
        if (mix_wide > SAT_MAX) begin
            mix_sat = SAT_MAX[OUT_W-1:0];
        end else if (mix_wide < SAT_MIN) begin
            mix_sat = SAT_MIN[OUT_W-1:0];
        end
    end

    // NOTE: every next-state signal gets its hold value first so that no path
    // through the case statement leaves a signal unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        maddr_d    = maddr_q;
        rhy_d      = rhy_q;
        tag0_vld_d = tag0_vld_q;
        tag0_d     = tag0_q;
        tag1_vld_d = tag1_vld_q;
        tag1_d     = tag1_q;
        acc_mel_d  = acc_mel_q;
        acc_rhy_d  = acc_rhy_q;
        mel_out_d  = mel_out_q;
        rhy_out_d  = rhy_out_q;
        mix_d      = mix_q;
        busy_d     = busy_q;
        overrun_d  = overrun_q;
        // The strobe drops on the next clk even when clkena is low.
        valid_d    = 1'b0;

        if (clkena) begin
            tag1_vld_d = tag0_vld_q;
            tag1_d     = tag0_q;
            tag0_vld_d = 1'b0;

            if (tag1_vld_q) begin
                if (to_mel) acc_mel_d = acc_mel_q + sample_val;
                if (to_rhy) acc_rhy_d = acc_rhy_q + sample_val;
            end

            if (start && busy_q) overrun_d = 1'b1;

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        rhy_d      = rhythm;
                        acc_mel_d  = '0;
                        acc_rhy_d  = '0;
                        maddr_d    = '0;
                        tag0_vld_d = 1'b1;
                        tag0_d     = '0;
                        busy_d     = 1'b1;
                        state_d    = S_READ;
                    end
                end
                S_READ: begin
                    maddr_d    = maddr_q + 5'd1;
                    tag0_vld_d = 1'b1;
                    tag0_d     = maddr_q + 5'd1;
                    if (maddr_q == PRE_LAST) state_d = S_DRAIN;
                end
                S_DRAIN: begin
                    // Leave once the last slot's data is being accumulated.
                    if (tag1_vld_q && (tag1_q == LAST_SLOT)) state_d = S_PUBLISH;
                end
                S_PUBLISH: begin
                    mel_out_d = acc_mel_q;
                    rhy_out_d = acc_rhy_q;
                    mix_d     = mix_sat;
                    valid_d   = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            maddr_q    <= '0;
            rhy_q      <= 1'b0;
            tag0_vld_q <= 1'b0;
            tag0_q     <= '0;
            tag1_vld_q <= 1'b0;
            tag1_q     <= '0;
            acc_mel_q  <= '0;
            acc_rhy_q  <= '0;
            mel_out_q  <= '0;
            rhy_out_q  <= '0;
            mix_q      <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            maddr_q    <= maddr_d;
            rhy_q      <= rhy_d;
            tag0_vld_q <= tag0_vld_d;
            tag0_q     <= tag0_d;
            tag1_vld_q <= tag1_vld_d;
            tag1_q     <= tag1_d;
            acc_mel_q  <= acc_mel_d;
            acc_rhy_q  <= acc_rhy_d;
            mel_out_q  <= mel_out_d;
            rhy_out_q  <= rhy_out_d;
            mix_q      <= mix_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
        end
    end

    assign maddr        = maddr_q;
    assign melody_out   = mel_out_q;
    assign rhythm_out   = rhy_out_q;
    assign mix_out      = mix_q;
    assign sample_valid = valid_q;
    assign busy         = busy_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_slot_output_mixer.sv
// -----------------------------------------------------------------------------
// tb_slot_output_mixer
//
// Drives frames through slot_output_mixer against a small output-memory model
// (one registered read stage gated by clkena) and compares each published
// sample with sums computed directly from the slot routing rules.
// -----------------------------------------------------------------------------
module tb_slot_output_mixer;

    localparam int NSLOTS = 18;
    localparam int ACC_W  = 14;
    localparam int OUT_W  = 14;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    clkena;
    logic                    start;
    logic                    rhythm;
    logic [4:0]              maddr;
    logic [9:0]              mdata;
    logic signed [ACC_W-1:0] melody_out;
    logic signed [ACC_W-1:0] rhythm_out;
    logic signed [OUT_W-1:0] mix_out;
    logic                    sample_valid;
    logic                    busy;
    logic                    overrun;

    logic [9:0] mem [NSLOTS];
    logic [9:0] rd_q = '0;

    int errors = 0;
    int checks = 0;

    slot_output_mixer #(
        .NSLOTS   (NSLOTS),
        .ACC_W    (ACC_W),
        .OUT_W    (OUT_W),
        .RHY_SHIFT(1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .clkena      (clkena),
        .start       (start),
        .rhythm      (rhythm),
        .maddr       (maddr),
        .mdata       (mdata),
        .melody_out  (melody_out),
        .rhythm_out  (rhythm_out),
        .mix_out     (mix_out),
        .sample_valid(sample_valid),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // Output memory read port: data for an address appears two enabled
    // cycles after the DUT registers that address.
    always @(posedge clk) begin
        if (clkena) rd_q <= (maddr < 5'(NSLOTS)) ? mem[maddr] : 10'd0;
    end
    assign mdata = rd_q;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int decode(input logic [9:0] w);
        int m;
        m = int'(w[8:0]);
        return w[9] ? -m : m;
    endfunction

    // Reference sums from the routing rules: channel = slot/2, odd = carrier.
    task automatic model(input bit rhy, output int mel, output int rh, output int mix);
        int lim;
        mel = 0;
        rh  = 0;
        for (int s = 0; s < NSLOTS; s++) begin
            int  v;
            int  ch;
            bit  carrier;
            v       = decode(mem[s]);
            ch      = s / 2;
            carrier = (s % 2) == 1;
            if (!rhy) begin
                if (carrier) mel += v;
            end else if (ch < 6) begin
                if (carrier) mel += v;
            end else if (s == 13 || s == 14 || s == 15 || s == 16 || s == 17) begin
                rh += v;
            end
        end
        lim = (1 << (OUT_W - 1)) - 1;
        mix = mel + 2 * rh;
        if (mix > lim)  mix = lim;
        if (mix < -lim) mix = -lim;
    endtask

    // en_mode: 0 = clkena always high, 1 = alternating 1/0, 2 = random.
    // restart: issue an extra start at E5. abort_at: assert reset after that
    // enabled cycle (negative = run to completion).
    task automatic run_frame(input bit rhy, input int en_mode, input bit restart,
                             input int abort_at, input string name);
        int  e;
        int  mel;
        int  rh;
        int  mix;
        bit  en;
        bit  phase;
        bit  got_valid;
        bit  seq_ok;
        bit  aborted;
        model(rhy, mel, rh, mix);
        e         = -1;
        phase     = 1'b1;
        got_valid = 1'b0;
        seq_ok    = 1'b1;
        aborted   = 1'b0;
        for (int cyc = 0; cyc < 400 && !got_valid && !aborted; cyc++) begin
            @(negedge clk);
            case (en_mode)
                1:       begin en = phase; phase = ~phase; end
                2:       en = ($urandom_range(0, 3) != 0);
                default: en = 1'b1;
            endcase
            clkena = en;
            start  = (e < 0) || (restart && e == 4);
            rhythm = (e < 0) ? rhy : ~rhy;
            @(posedge clk);
            if (en && (e >= 0 || start)) e++;
            #1;
            if (en && e >= 0 && e < NSLOTS && maddr !== 5'(e)) seq_ok = 1'b0;
            if (en && e == 0) check({name, " busy_at_E0"}, int'(busy), 1);
            if (sample_valid) begin
                got_valid = 1'b1;
                check({name, " publish_cycle"}, e, 20);
                check({name, " melody_out"}, int'(melody_out), mel);
                check({name, " rhythm_out"}, int'(rhythm_out), rh);
                check({name, " mix_out"}, int'(mix_out), mix);
                check({name, " busy_at_publish"}, int'(busy), 0);
            end
            if (en && abort_at >= 0 && e == abort_at) begin
                aborted = 1'b1;
                #2 reset = 1'b1;
                #1;
                check({name, " abort_melody"}, int'(melody_out), 0);
                check({name, " abort_mix"}, int'(mix_out), 0);
                check({name, " abort_busy"}, int'(busy), 0);
                check({name, " abort_overrun"}, int'(overrun), 0);
                check({name, " abort_maddr"}, int'(maddr), 0);
                @(negedge clk);
                reset = 1'b0;
            end
        end
        check({name, " maddr_sequence"}, int'(seq_ok), 1);
        if (aborted) begin
            bit seen;
            seen   = 1'b0;
            start  = 1'b0;
            clkena = 1'b1;
            for (int i = 0; i < 30; i++) begin
                @(posedge clk);
                #1;
                if (sample_valid) seen = 1'b1;
            end
            check({name, " no_valid_after_abort"}, int'(seen), 0);
            check({name, " outputs_after_abort"}, int'(melody_out), 0);
        end else begin
            check({name, " valid_seen"}, int'(got_valid), 1);
            // The strobe must drop on the next clk even with clkena low.
            @(negedge clk);
            clkena = 1'b0;
            start  = 1'b0;
            @(posedge clk);
            #1;
            check({name, " valid_width"}, int'(sample_valid), 0);
            @(negedge clk);
            clkena = 1'b1;
        end
    endtask

    task automatic fill_pattern2();
        for (int s = 0; s < NSLOTS; s++) mem[s] = (s % 2 == 1) ? 10'h064 : 10'h1FF;
    endtask

    initial begin
        reset  = 1'b1;
        clkena = 1'b0;
        start  = 1'b0;
        rhythm = 1'b0;
        for (int s = 0; s < NSLOTS; s++) mem[s] = 10'h000;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset maddr", int'(maddr), 0);
        check("reset busy", int'(busy), 0);
        check("reset sample_valid", int'(sample_valid), 0);
        check("reset melody_out", int'(melody_out), 0);
        check("reset rhythm_out", int'(rhythm_out), 0);
        check("reset mix_out", int'(mix_out), 0);
        check("reset overrun", int'(overrun), 0);
        @(negedge clk);
        reset  = 1'b0;
        clkena = 1'b1;
        repeat (2) @(negedge clk);

        // Melody mode, odd +100, even +511 -> 900
        fill_pattern2();
        run_frame(1'b0, 0, 1'b0, -1, "s2");
        check("s2 overrun", int'(overrun), 0);

        // Negative full scale and negative zero
        for (int s = 0; s < NSLOTS; s++) mem[s] = (s % 2 == 1) ? 10'h000 : 10'h1FF;
        mem[1] = 10'h3FF;
        mem[3] = 10'h200;
        run_frame(1'b0, 0, 1'b0, -1, "s3");

        // Rhythm mode, all +200 -> 1200 / 1000 / 3200
        for (int s = 0; s < NSLOTS; s++) mem[s] = 10'h0C8;
        run_frame(1'b1, 0, 1'b0, -1, "s4");

        // Gated clock plus a start while busy
        fill_pattern2();
        run_frame(1'b0, 1, 1'b1, -1, "s5");
        check("s5 overrun_set", int'(overrun), 1);

        // Full frame, then abort one with reset at E10, then a clean frame
        run_frame(1'b0, 0, 1'b0, -1, "s6a");
        check("s6a overrun_sticky", int'(overrun), 1);
        run_frame(1'b0, 0, 1'b0, 10, "s6b");
        run_frame(1'b0, 0, 1'b0, -1, "s6c");
        check("s6c overrun", int'(overrun), 0);

        // Randomized frames
        for (int f = 0; f < 8; f++) begin
            bit rhy;
            for (int s = 0; s < NSLOTS; s++) mem[s] = 10'($urandom_range(0, 1023));
            rhy = 1'($urandom_range(0, 1));
            run_frame(rhy, int'($urandom_range(0, 2)), 1'b0, -1, $sformatf("rnd%0d", f));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/slot_output_mixer.md
Name: slot_output_mixer

Overview:
Reader side of the per-slot operator output memory in the VM2413 core.
- Once per sample frame, sweeps all 18 slot entries through the memory's second read port (maddr/mdata).
- Converts each sign+magnitude sample to two's complement.
- Accumulates carrier outputs into separate melody and rhythm sums, then publishes a mixed audio sample with a one-clock valid strobe.

Parameters:
NSLOTS, 18, slots swept per frame; slot s = channel s/2, s odd = carrier.
ACC_W, 14, signed width of the melody/rhythm accumulators and their outputs.
OUT_W, 14, signed width of mix_out.
RHY_SHIFT, 1, left shift (gain) applied to the rhythm sum before mixing.

Ports:
clk  in  1  clock.
reset  in  1  asynchronous, active-high reset.
clkena  in  1  clock enable; all state advances only on clk edges with clkena=1.
start  in  1  frame start request, sampled on clkena cycles.
rhythm  in  1  rhythm-mode flag, latched when start is accepted.
maddr  out  5  slot address to the output memory read port (registered).
mdata  in  10  read data; [9]=sign (1=negative), [8:0]=magnitude 0..511.
melody_out  out  ACC_W  signed melody sum of the last completed frame.
rhythm_out  out  ACC_W  signed rhythm sum of the last completed frame.
mix_out  out  OUT_W  saturated melody_out + (rhythm_out <<< RHY_SHIFT).
sample_valid  out  1  one-clk pulse when the outputs update.
busy  out  1  high from start acceptance until sample_valid.
overrun  out  1  sticky; set when start arrives while busy.

Behaviour:
- Reset (async, any time): state IDLE; maddr=0; all sums/outputs 0; sample_valid=0; busy=0; overrun=0.
- Reset mid-frame aborts the frame: no sample_valid, outputs stay 0.
- FSM states: IDLE, READ, DRAIN, PUBLISH.
- Clkena cycles are numbered E0..E20 from start acceptance.
- IDLE:
  - On clkena with start=1: latch rhythm into rhy_q, clear both accumulators, maddr<=0, busy<=1, go READ. This is E0.
- READ:
  - At E1..E17: maddr<=1..17.
  - After issuing 17, go DRAIN.
- Read latency: mdata for address A is valid on the 2nd clkena cycle after the one that loaded A. A 2-deep slot-tag pipeline tracks this.
  - Slot i is sampled and accumulated at E(i+2), i.e. E2..E19.
  - DRAIN covers E18..E19.
- PUBLISH (E20):
  - Register the accumulators into melody_out, rhythm_out and mix_out.
  - sample_valid=1 for exactly one clk; busy<=0; go IDLE.
  - A start seen at E20 is not accepted. The earliest next start is the following clkena cycle.
- clkena=0 freezes all state. sample_valid still lasts exactly one clk, because it is cleared on the next clk regardless of clkena.
- Conversion: v = sign ? -mag : +mag, sign-extended to ACC_W. Negative zero (sign=1, mag=0) yields 0.
- Routing with rhy_q=0:
  - Odd slots 1,3,..,17 go to melody.
  - Even slots are discarded.
- Routing with rhy_q=1:
  - Odd slots 1..11 (ch0-5) go to melody.
  - Slot 13 (BD carrier) and slots 14,15,16,17 (HH,SD,TOM,CYM) go to rhythm.
  - All other even slots, including 12 (BD modulator), are discarded.
- All 18 slots are always read, regardless of mode.
- Ranges: melody |sum| <= 9*511 = 4599; rhythm |sum| <= 5*511 = 2555. Accumulators cannot overflow at default widths.
- mix_out saturates to [-(2^(OUT_W-1)-1), 2^(OUT_W-1)-1].
- start while busy (E1..E20): ignored; overrun<=1 until reset; the frame in progress is unaffected.
- A change of the rhythm input mid-frame has no effect; rhy_q holds for the whole frame.

Test Plan:
1. Reset with outputs driven -> all outputs 0, maddr=0, busy=0. Assert reset for 1 clk mid-stream -> same values asynchronously.
2. rhythm=0, every odd slot mdata=+100 (0x064), every even slot +511; clkena=1 continuous, pulse start -> maddr runs 0..17. sample_valid pulses at E20 with melody_out=900, rhythm_out=0, mix_out=900.
3. rhythm=0: slot 1 = -511 (0x3FF), slot 3 = negative zero (0x200), other odd slots +0 -> melody_out=-511, mix_out=-511.
4. rhythm=1, all 18 slots +200 -> melody_out=1200, rhythm_out=1000, mix_out=1200+2000=3200. Slot 12 is excluded.
5. clkena toggling 1/0 with start repeated at E5 -> frame completes after 20 enabled cycles; result equals scenario 2; overrun=1 and stays 1; sample_valid width is 1 clk.
6. Complete one frame (outputs 900), then start a new frame and assert reset at E10 -> no sample_valid; melody_out=0, busy=0, overrun=0. A following full frame yields the correct sums.
